// File: rtl/axi_lite_regbank.sv
// AXI4-Lite slave register bank: RW registers with byte strobes and per-register write pulses,
// plus a read-only status window at the top indices.
module axi_lite_regbank #(
    parameter int unsigned              C_DATA_WIDTH = 32,
    parameter int unsigned              C_ADDR_WIDTH = 8,
    parameter int unsigned              C_NUM_REGS   = 16,
    parameter int unsigned              C_NUM_RO     = 4,
    parameter logic [C_DATA_WIDTH-1:0]  C_RESET_VAL  = '0
) (
    input  logic                                           ACLK,
    input  logic                                           ARESET,
    input  logic [C_ADDR_WIDTH-1:0]                        S_AXI_AWADDR,
    input  logic [2:0]                                     S_AXI_AWPROT,
    input  logic                                           S_AXI_AWVALID,
    output logic                                           S_AXI_AWREADY,
    input  logic [C_DATA_WIDTH-1:0]                        S_AXI_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]                      S_AXI_WSTRB,
    input  logic                                           S_AXI_WVALID,
    output logic                                           S_AXI_WREADY,
    output logic [1:0]                                     S_AXI_BRESP,
    output logic                                           S_AXI_BVALID,
    input  logic                                           S_AXI_BREADY,
    input  logic [C_ADDR_WIDTH-1:0]                        S_AXI_ARADDR,
    input  logic [2:0]                                     S_AXI_ARPROT,
    input  logic                                           S_AXI_ARVALID,
    output logic                                           S_AXI_ARREADY,
    output logic [C_DATA_WIDTH-1:0]                        S_AXI_RDATA,
    output logic [1:0]                                     S_AXI_RRESP,
    output logic                                           S_AXI_RVALID,
    input  logic                                           S_AXI_RREADY,
    output logic [(C_NUM_REGS-C_NUM_RO)*C_DATA_WIDTH-1:0]  reg_out,
    output logic [C_NUM_REGS-C_NUM_RO-1:0]                 wr_pulse,
    input  logic [((C_NUM_RO > 0) ? C_NUM_RO : 1)*C_DATA_WIDTH-1:0] status_in
);

    localparam int unsigned StrbW   = C_DATA_WIDTH / 8;
    localparam int unsigned AddrLsb = $clog2(StrbW);
    localparam int unsigned NumRw   = C_NUM_REGS - C_NUM_RO;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic {StWIdle, StWResp} wstate_e;
    typedef enum logic {StRIdle, StRData} rstate_e;

    wstate_e                   wstate_q, wstate_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic [C_ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [C_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [StrbW-1:0]          wstrb_q, wstrb_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [NumRw-1:0]          wr_pulse_q, wr_pulse_d;
    logic [C_DATA_WIDTH-1:0]   regs_q [NumRw];
    logic [C_DATA_WIDTH-1:0]   regs_d [NumRw];

    rstate_e                   rstate_q, rstate_d;
    logic [C_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                rresp_q, rresp_d;

    logic                      awready, wready, aw_hs, w_hs;
    logic [C_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_DATA_WIDTH-1:0]   wr_data;
    logic [StrbW-1:0]          wr_strb;
    logic [31:0]               wr_idx, rd_idx;

    // Write channel: AW and W are captured independently; the write commits once both are held.
    always_comb begin
        wstate_d   = wstate_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;
        aw_hs      = 1'b0;
        w_hs       = 1'b0;
        wr_addr    = awaddr_q;
        wr_data    = wdata_q;
        wr_strb    = wstrb_q;
        wr_idx     = '0;
        awready    = (wstate_q == StWIdle) && !aw_done_q;
        wready     = (wstate_q == StWIdle) && !w_done_q;

        unique case (wstate_q)
            StWIdle: begin
                aw_hs = S_AXI_AWVALID && awready;
                w_hs  = S_AXI_WVALID && wready;
                if (aw_hs) begin
                    awaddr_d  = S_AXI_AWADDR;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    wr_addr   = aw_hs ? S_AXI_AWADDR : awaddr_q;
                    wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
                    wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
                    wr_idx    = 32'(wr_addr[C_ADDR_WIDTH-1:AddrLsb]);
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    wstate_d  = StWResp;
                    if (wr_idx < NumRw) begin
                        bresp_d = RespOkay;
                        for (int unsigned i = 0; i < NumRw; i++) begin
                            if (wr_idx == i) begin
                                wr_pulse_d[i] = 1'b1;
                                for (int unsigned b = 0; b < StrbW; b++) begin
                                    if (wr_strb[b]) begin
                                        regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                                    end
                                end
                            end
                        end
                    end else if (wr_idx < C_NUM_REGS) begin
                        bresp_d = RespSlvErr;
                    end else begin
                        bresp_d = RespDecErr;
                    end
                end
            end
            StWResp: begin
                if (S_AXI_BREADY) begin
                    wstate_d = StWIdle;
                end
            end
            default: wstate_d = StWIdle;
        endcase
    end

    // Read channel: data is sampled from the current flops, so a same-edge write is not seen.
    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rd_idx   = 32'(S_AXI_ARADDR[C_ADDR_WIDTH-1:AddrLsb]);

        unique case (rstate_q)
            StRIdle: begin
                if (S_AXI_ARVALID) begin
                    rstate_d = StRData;
                    rdata_d  = '0;
                    rresp_d  = (rd_idx < C_NUM_REGS) ? RespOkay : RespDecErr;
                    for (int unsigned i = 0; i < NumRw; i++) begin
                        if (rd_idx == i) begin
                            rdata_d = regs_q[i];
                        end
                    end
                    for (int unsigned i = 0; i < C_NUM_RO; i++) begin
                        if (rd_idx == NumRw + i) begin
                            rdata_d = status_in[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                        end
                    end
                end
            end
            StRData: begin
                if (S_AXI_RREADY) begin
                    rstate_d = StRIdle;
                end
            end
            default: rstate_d = StRIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wstate_q   <= StWIdle;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RespOkay;
            wr_pulse_q <= '0;
            for (int unsigned i = 0; i < NumRw; i++) begin
                regs_q[i] <= C_RESET_VAL;
            end
            rstate_q   <= StRIdle;
            rdata_q    <= '0;
            rresp_q    <= RespOkay;
        end else begin
            wstate_q   <= wstate_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            rstate_q   <= rstate_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NumRw; i++) begin
            reg_out[i*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[i];
        end
    end

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BVALID  = (wstate_q == StWResp);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = (rstate_q == StRIdle);
    assign S_AXI_RVALID  = (rstate_q == StRData);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[AddrLsb-1:0],
                             S_AXI_ARADDR[AddrLsb-1:0]};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed and randomized AXI4-Lite transactions against a register-array reference model.
module tb_axi_lite_regbank;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [7:0]   S_AXI_AWADDR = '0;
    logic [2:0]   S_AXI_AWPROT = '0;
    logic         S_AXI_AWVALID = 1'b0;
    logic         S_AXI_AWREADY;
    logic [31:0]  S_AXI_WDATA = '0;
    logic [3:0]   S_AXI_WSTRB = '0;
    logic         S_AXI_WVALID = 1'b0;
    logic         S_AXI_WREADY;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY = 1'b0;
    logic [7:0]   S_AXI_ARADDR = '0;
    logic [2:0]   S_AXI_ARPROT = '0;
    logic         S_AXI_ARVALID = 1'b0;
    logic         S_AXI_ARREADY;
    logic [31:0]  S_AXI_RDATA;
    logic [1:0]   S_AXI_RRESP;
    logic         S_AXI_RVALID;
    logic         S_AXI_RREADY = 1'b0;
    logic [383:0] reg_out;
    logic [11:0]  wr_pulse;
    logic [127:0] status_in;

    logic [31:0]  mreg [12];
    logic [31:0]  stat [4];
    int           tests = 0;
    int           fails = 0;

    assign status_in = {stat[3], stat[2], stat[1], stat[0]};

    always #5 ACLK = ~ACLK;

    axi_lite_regbank dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse),
        .status_in     (status_in)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("reg_out[%0d]", i), 64'(reg_out[i*32 +: 32]), 64'(mreg[i]));
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 12; i++) mreg[i] = 32'h0;
    endtask

    // Leaves the bench at the negedge after the reset edge.
    task automatic do_reset();
        @(posedge ACLK); #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        model_reset();
        @(negedge ACLK);
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 4'b0000);
        check("rst_rdata", S_AXI_RDATA, 32'h0);
        check("rst_wr_pulse", wr_pulse, 12'h0);
        check_regs();
    endtask

    // lead > 0: W presented lead cycles before AW; lead < 0: AW first.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int lead, input int bhold,
                            input bit complete);
        int         idx;
        logic [1:0] eresp;
        logic [11:0] epulse;
        bit         aw_ok, w_ok, acc_aw, acc_w;
        int         aw_start, w_start;
        idx      = int'(addr[7:2]);
        epulse   = '0;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        if (idx < 12) begin
            eresp       = 2'b00;
            epulse[idx] = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mreg[idx][8*b +: 8] = data[8*b +: 8];
            end
        end else if (idx < 16) begin
            eresp = 2'b10;
        end else begin
            eresp = 2'b11;
        end
        aw_ok = 1'b0;
        w_ok  = 1'b0;
        @(posedge ACLK); #1;
        for (int n = 0; n < 20 && !(aw_ok && w_ok); n++) begin
            if (n == aw_start) begin
                S_AXI_AWADDR  = addr;
                S_AXI_AWVALID = 1'b1;
            end
            if (n == w_start) begin
                S_AXI_WDATA  = data;
                S_AXI_WSTRB  = strb;
                S_AXI_WVALID = 1'b1;
            end
            @(negedge ACLK);
            acc_aw = S_AXI_AWVALID && S_AXI_AWREADY;
            acc_w  = S_AXI_WVALID && S_AXI_WREADY;
            if (n < aw_start || n < w_start) check("bvalid_early", S_AXI_BVALID, 1'b0);
            @(posedge ACLK); #1;
            if (acc_aw) begin
                aw_ok = 1'b1;
                S_AXI_AWVALID = 1'b0;
            end
            if (acc_w) begin
                w_ok = 1'b1;
                S_AXI_WVALID = 1'b0;
            end
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        check("aw_w_accepted", {aw_ok, w_ok}, 2'b11);
        @(negedge ACLK);
        check("bvalid_rise", S_AXI_BVALID, 1'b1);
        check("bresp", S_AXI_BRESP, eresp);
        check("wr_pulse_first", wr_pulse, epulse);
        if (complete) begin
            for (int k = 0; k < bhold; k++) begin
                @(negedge ACLK);
                check("bvalid_hold", S_AXI_BVALID, 1'b1);
                check("bresp_hold", S_AXI_BRESP, eresp);
                check("awready_wready_low", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b00);
                check("wr_pulse_single", wr_pulse, 12'h0);
            end
            S_AXI_BREADY = 1'b1;
            @(posedge ACLK); #1;
            S_AXI_BREADY = 1'b0;
            @(negedge ACLK);
            check("bvalid_drop", S_AXI_BVALID, 1'b0);
            check("ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
            check("wr_pulse_after", wr_pulse, 12'h0);
            check_regs();
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input int rhold);
        int          idx;
        logic [31:0] edata;
        logic [1:0]  eresp;
        bit          ok, acc;
        idx = int'(addr[7:2]);
        if (idx < 12) begin
            edata = mreg[idx];
            eresp = 2'b00;
        end else if (idx < 16) begin
            edata = stat[idx-12];
            eresp = 2'b00;
        end else begin
            edata = 32'h0;
            eresp = 2'b11;
        end
        ok = 1'b0;
        @(posedge ACLK); #1;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge ACLK);
            acc = S_AXI_ARVALID && S_AXI_ARREADY;
            @(posedge ACLK); #1;
            if (acc) ok = 1'b1;
        end
        S_AXI_ARVALID = 1'b0;
        check("ar_accepted", ok, 1'b1);
        @(negedge ACLK);
        check("rvalid_rise", S_AXI_RVALID, 1'b1);
        check("rdata", S_AXI_RDATA, edata);
        check("rresp", S_AXI_RRESP, eresp);
        for (int k = 0; k < rhold; k++) begin
            @(negedge ACLK);
            check("rvalid_hold", S_AXI_RVALID, 1'b1);
            check("rdata_hold", S_AXI_RDATA, edata);
            check("rresp_hold", S_AXI_RRESP, eresp);
            check("arready_low", S_AXI_ARREADY, 1'b0);
        end
        S_AXI_RREADY = 1'b1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 1'b0;
        @(negedge ACLK);
        check("rvalid_drop", S_AXI_RVALID, 1'b0);
        check("arready_back", S_AXI_ARREADY, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired (observed hang, required finish)");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ri;
        logic [7:0] ra;
        model_reset();
        stat[0] = 32'h0000_0A0A;
        stat[1] = 32'hDEAD_BEEF;
        stat[2] = 32'h1234_5678;
        stat[3] = 32'hCAFE_F00D;

        do_reset();

        // Single write, AW and W together, then read back.
        do_write(8'h00, 32'h0000_0001, 4'hF, 0, 0, 1'b1);
        check("reg0_is_one", 64'(reg_out[31:0]), 64'h1);
        do_read(8'h00, 0);

        // Four sequential writes and read-back.
        for (int i = 0; i < 4; i++) do_write(8'(4 * i), 32'(i + 1), 4'hF, 0, 0, 1'b1);
        for (int i = 0; i < 4; i++) do_read(8'(4 * i), 0);

        // W three cycles ahead of AW with partial strobes.
        do_write(8'h04, 32'h1122_3344, 4'hF, 0, 0, 1'b1);
        do_write(8'h04, 32'hAABB_CCDD, 4'h5, 3, 0, 1'b1);
        check("strobe_merge", 64'(reg_out[63:32]), 64'h11BB_33DD);
        do_write(8'h08, 32'h0BAD_0BAD, 4'hF, -2, 0, 1'b1);
        do_write(8'h0C, 32'hFFFF_FFFF, 4'h0, 0, 0, 1'b1);

        // RO, out-of-range and status reads.
        do_write(8'h30, 32'h5555_5555, 4'hF, 0, 0, 1'b1);
        do_write(8'h40, 32'h6666_6666, 4'hF, 0, 0, 1'b1);
        do_read(8'h40, 0);
        do_read(8'h34, 0);
        do_read(8'h2E, 0);

        // Backpressure on both response channels.
        do_write(8'h14, 32'h0F0F_1234, 4'hF, 0, 5, 1'b1);
        do_read(8'h14, 5);

        // Reset while BVALID is pending.
        do_write(8'h08, 32'h5A5A_5A5A, 4'hF, 0, 0, 1'b0);
        #1;
        ARESET = 1'b1;
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        model_reset();
        @(negedge ACLK);
        check("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
        check("mid_rst_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
        check_regs();
        do_write(8'h08, 32'h7777_8888, 4'hC, 1, 0, 1'b1);

        // Randomized mix including ignored low address bits.
        for (int t = 0; t < 40; t++) begin
            ri = 6'($urandom_range(0, 19));
            ra = {ri, 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) == 0) stat[$urandom_range(0, 3)] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(ra, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                         int'($urandom_range(0, 2)), 1'b1);
            end else begin
                do_read(ra, int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_lite_regbank.md
Name: axi_lite_regbank

Overview:
- Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register S00_AXI slave of eth_udp_axi_arp_stack.
- Generalised in data width, register count and read-only status region.
- Adds byte strobes, per-register write pulses and SLVERR/DECERR responses.
- Sits between the AXI interconnect and stack control/status logic (MAC/IP/port config, ARP/UDP counters).

Parameters:
C_DATA_WIDTH, 32, AXI data width; 32 or 64.
C_ADDR_WIDTH, 8, AXI address width; must cover C_NUM_REGS*(C_DATA_WIDTH/8) bytes.
C_NUM_REGS, 16, total register count, >=2.
C_NUM_RO, 4, read-only registers at the top indices (C_NUM_REGS-C_NUM_RO .. C_NUM_REGS-1); 0..C_NUM_REGS-1.
C_RESET_VAL, 0, reset value of every RW register.

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  C_DATA_WIDTH  write data
S_AXI_WSTRB  in  C_DATA_WIDTH/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  C_DATA_WIDTH  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  (C_NUM_REGS-C_NUM_RO)*C_DATA_WIDTH  RW register contents, index 0 in LSBs
wr_pulse  out  C_NUM_REGS-C_NUM_RO  one-cycle strobe per RW register on accepted write
status_in  in  C_NUM_RO*C_DATA_WIDTH  RO register values, sampled at read time

Behaviour:
- Reset (ARESET=1 at a rising ACLK edge): all RW registers = C_RESET_VAL. AWREADY=WREADY=ARREADY=1. BVALID=RVALID=0. BRESP=RRESP=0. RDATA=0. wr_pulse=0.
- Reset mid-transaction: any pending AW/W/B/R is discarded; no register update.
- Decode: index = addr[C_ADDR_WIDTH-1 : log2(C_DATA_WIDTH/8)]; low byte-offset bits ignored.
- Write channel FSM, states W_IDLE / W_RESP:
  - W_IDLE: AWREADY high until AW is captured, WREADY high until W is captured. AW and W are accepted independently, in either order or in the same cycle.
  - On the edge where the second of AW/W is captured: perform the write, assert BVALID, drop AWREADY and WREADY, enter W_RESP.
- Write effect:
  - Index < C_NUM_REGS-C_NUM_RO: bytes with WSTRB=1 are updated. BRESP=OKAY(00). wr_pulse[index]=1 for exactly the cycle BVALID first rises, even when WSTRB=0.
  - RO index: no change, BRESP=SLVERR(10), no pulse.
  - Index >= C_NUM_REGS: no change, BRESP=DECERR(11), no pulse.
- W_RESP: hold BVALID and BRESP until BREADY. On the BVALID&BREADY edge: BVALID=0, AWREADY=WREADY=1, return to W_IDLE. Only one write is outstanding at a time.
- Read channel FSM, states R_IDLE / R_DATA:
  - R_IDLE: ARREADY=1. On ARVALID: RVALID=1, ARREADY=0, enter R_DATA; RDATA/RRESP are registered from the decoded index (1-cycle latency).
  - Read data: RW index returns the register value, OKAY. RO index returns status_in slice, OKAY. Out-of-range returns 0, DECERR.
  - R_DATA: RDATA/RRESP stable until RREADY. On the RVALID&RREADY edge: RVALID=0, ARREADY=1.
- Read and write channels are fully independent. A read accepted on the same edge as a write to the same register returns the pre-write value.
- reg_out is updated combinationally from the register flops (new value visible the cycle after the write edge).

Test Plan:
- Reset, then AW and W in the same cycle to addr 0x00, data 0x00000001, WSTRB=F, BREADY=1 -> BRESP=00; reg_out[31:0]=1; wr_pulse[0] high for one cycle; read addr 0x00 returns 0x00000001, RRESP=00.
- Four sequential writes 1..4 to addr 0x0,0x4,0x8,0xC, then read back all four -> data 1,2,3,4, all OKAY.
- W issued 3 cycles before AW to addr 0x04 with data 0xAABBCCDD, WSTRB=0x5, prior value 0x11223344 -> register = 0x11BB33DD; one BVALID.
- With C_NUM_REGS=16, C_NUM_RO=4: write 0x30 -> SLVERR, no change, no pulse. Write or read 0x40 -> DECERR, RDATA=0. Read 0x34 with status_in slice 1 = 0xDEADBEEF -> 0xDEADBEEF, OKAY.
- BREADY/RREADY held low 5 cycles -> BVALID/RVALID, BRESP, RDATA stable throughout; AWREADY/WREADY/ARREADY stay low until the response handshake.
- ARESET asserted while BVALID is pending -> next cycle BVALID=0, AWREADY=WREADY=1, all RW registers back to C_RESET_VAL.
